// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - LSU_XLEN           : default data/address width
//  - SZ_B / SZ_H / SZ_W : req_size encodings (2'b11 is illegal)
//  - BYTE_BITS/HALF_BITS: lane widths used by the extract/merge logic
//  - lsu_state_e        : controller state encoding
//  - is_misaligned()    : alignment check for a size / low-address pair
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Size 11 is treated as misaligned so that it takes the fault path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad_s;
    case (size)
      SZ_B:    bad_s = 1'b0;
      SZ_H:    bad_s = addr_lo[0];
      SZ_W:    bad_s = (addr_lo != 2'b00);
      default: bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//  size        in  2     access size (SZ_B / SZ_H / SZ_W)
//  addr_lo     in  2     byte offset within the word
//  is_unsigned in  1     zero-extend loads instead of sign-extend
//  load_word   in  XLEN  raw RAM word for load extraction
//  merge_base  in  XLEN  previously read RAM word for store merging
//  store_data  in  XLEN  store value (sub-word values in the low bits)
//  load_data   out XLEN  extracted and extended load value
//  store_word  out XLEN  full word to write back
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] load_word,
  input  logic [XLEN-1:0] merge_base,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [BYTE_BITS-1:0] byte_s;
  logic [HALF_BITS-1:0] half_s;

  // Pick the addressed byte and half lanes out of the RAM word.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = load_word[7:0];
      2'b01:   byte_s = load_word[15:8];
      2'b10:   byte_s = load_word[23:16];
      default: byte_s = load_word[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = load_word[31:16];
    end else begin
      half_s = load_word[15:0];
    end
  end

  // Sign- or zero-extend the selected lane to the full width.
  always_comb begin
    case (size)
      SZ_B: begin
        if (is_unsigned) begin
          load_data = {{(XLEN-BYTE_BITS){1'b0}}, byte_s};
        end else begin
          load_data = {{(XLEN-BYTE_BITS){byte_s[BYTE_BITS-1]}}, byte_s};
        end
      end
      SZ_H: begin
        if (is_unsigned) begin
          load_data = {{(XLEN-HALF_BITS){1'b0}}, half_s};
        end else begin
          load_data = {{(XLEN-HALF_BITS){half_s[HALF_BITS-1]}}, half_s};
        end
      end
      SZ_W:    load_data = load_word;
      default: load_data = {XLEN{1'b0}};
    endcase
  end

  // Replace the addressed lane of the old word with the store value.
  always_comb begin
    store_word = merge_base;
    case (size)
      SZ_B:    store_word[{addr_lo, 3'b000} +: BYTE_BITS] = store_data[BYTE_BITS-1:0];
      SZ_H:    store_word[{addr_lo[1], 4'b0000} +: HALF_BITS] = store_data[HALF_BITS-1:0];
      SZ_W:    store_word = store_data;
      default: store_word = merge_base;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the EX/MEM register and a word-only data RAM.
// Byte/half/word requests become word-indexed RAM cycles; sub-word stores
// use read-modify-write; faulting accesses never touch the RAM.
//  clk, rst_n                 clock, async active-low reset
//  req_valid/req_ready        request handshake (ready only in IDLE)
//  req_we/size/unsigned/addr/wdata   request fields
//  resp_valid                 one-cycle completion pulse
//  resp_rdata                 extended load data (0 for stores/faults)
//  resp_misalign, resp_range  fault flags, valid with resp_valid
//  mem_addr                   RAM word index
//  mem_lw_en, mem_sw_en       RAM read / write enables
//  mem_wdata, mem_rdata       RAM write / read words
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN      = LSU_XLEN,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            resp_range,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_lw_en,
  output logic            mem_sw_en,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_r;
  logic            ready_r;
  logic            resp_valid_r;
  logic [XLEN-1:0] resp_rdata_r;
  logic            resp_mis_r;
  logic            resp_rng_r;
  logic [XLEN-1:0] mem_addr_r;
  logic            lw_en_r;
  logic            sw_en_r;
  logic [XLEN-1:0] wdata_hold_r;

  logic [1:0]      addr_lo_r;
  logic [1:0]      size_r;
  logic            we_r;
  logic            uns_r;
  logic [XLEN-1:0] wdata_r;
  logic [XLEN-1:0] rbuf_r;

  logic [XLEN-3:0] idx_s;
  logic            mis_s;
  logic            rng_s;
  logic [XLEN-1:0] load_data_s;
  logic [XLEN-1:0] store_word_s;

  assign idx_s = req_addr[XLEN-1:2];
  assign mis_s = is_misaligned(req_size, req_addr[1:0]);
  assign rng_s = (idx_s >= (XLEN-2)'(MEM_DEPTH));

  // Load lanes come straight from the RAM during RD; the store merge uses
  // the word captured in rbuf at the end of RD.
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size        (size_r),
    .addr_lo     (addr_lo_r),
    .is_unsigned (uns_r),
    .load_word   (mem_rdata),
    .merge_base  (rbuf_r),
    .store_data  (wdata_r),
    .load_data   (load_data_s),
    .store_word  (store_word_s)
  );

  assign req_ready     = ready_r;
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_misalign = resp_mis_r;
  assign resp_range    = resp_rng_r;
  assign mem_addr      = mem_addr_r;
  assign mem_lw_en     = lw_en_r;
  assign mem_sw_en     = sw_en_r;
  // Live merge during WR, last written word everywhere else.
  assign mem_wdata     = (state_r == ST_WR) ? store_word_s : wdata_hold_r;

  // Controller FSM with request capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
      resp_mis_r   <= 1'b0;
      resp_rng_r   <= 1'b0;
      mem_addr_r   <= {XLEN{1'b0}};
      lw_en_r      <= 1'b0;
      sw_en_r      <= 1'b0;
      wdata_hold_r <= {XLEN{1'b0}};
      addr_lo_r    <= 2'b00;
      size_r       <= 2'b00;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      wdata_r      <= {XLEN{1'b0}};
      rbuf_r       <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            addr_lo_r <= req_addr[1:0];
            size_r    <= req_size;
            we_r      <= req_we;
            uns_r     <= req_unsigned;
            wdata_r   <= req_wdata;
            ready_r   <= 1'b0;
            if (mis_s || rng_s) begin
              // Faults skip the RAM entirely; mem_addr keeps its old value.
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= {XLEN{1'b0}};
              resp_mis_r   <= mis_s;
              resp_rng_r   <= rng_s;
            end else if (req_we && (req_size == SZ_W)) begin
              state_r    <= ST_WR;
              sw_en_r    <= 1'b1;
              mem_addr_r <= {2'b00, idx_s};
            end else begin
              state_r    <= ST_RD;
              lw_en_r    <= 1'b1;
              mem_addr_r <= {2'b00, idx_s};
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_RD: begin
          lw_en_r <= 1'b0;
          rbuf_r  <= mem_rdata;
          if (we_r) begin
            state_r <= ST_WR;
            sw_en_r <= 1'b1;
          end else begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_data_s;
            resp_mis_r   <= 1'b0;
            resp_rng_r   <= 1'b0;
          end
        end
        ST_WR: begin
          sw_en_r      <= 1'b0;
          wdata_hold_r <= store_word_s;
          state_r      <= ST_RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= {XLEN{1'b0}};
          resp_mis_r   <= 1'b0;
          resp_rng_r   <= 1'b0;
        end
        ST_RESP: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= {XLEN{1'b0}};
          resp_mis_r   <= 1'b0;
          resp_rng_r   <= 1'b0;
          ready_r      <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          ready_r      <= 1'b1;
          resp_valid_r <= 1'b0;
          lw_en_r      <= 1'b0;
          sw_en_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected
// responses; a monitor pops and compares on every resp_valid.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_range;
  logic [31:0] mem_addr;
  logic        mem_lw_en;
  logic        mem_sw_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:255];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        rng;
    int          lat;
    int          lw;
    int          sw;
    logic [31:0] idx;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lw_cnt  = 0;
  int   sw_cnt  = 0;

  lsu_mem_ctrl #(.XLEN(32), .MEM_DEPTH(256)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_range    (resp_range),
    .mem_addr      (mem_addr),
    .mem_lw_en     (mem_lw_en),
    .mem_sw_en     (mem_sw_en),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the falling edge.
  assign mem_rdata = mem_lw_en ? ram[mem_addr[7:0]] : 32'h0;
  always @(negedge clk) begin
    if (mem_sw_en) ram[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count enables, check RAM index, pop and compare responses.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc = cyc + 1;
    if (rst_n) begin
      if ((mem_lw_en || mem_sw_en) && (sb.size() > 0)) begin
        if (mem_lw_en) lw_cnt = lw_cnt + 1;
        if (mem_sw_en) sw_cnt = sw_cnt + 1;
        chk("mem_addr", mem_addr, sb[0].idx);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_misalign", {31'd0, resp_misalign}, {31'd0, e.mis});
          chk("resp_range", {31'd0, resp_range}, {31'd0, e.rng});
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("lw_cycles", lw_cnt, e.lw);
          chk("sw_cycles", sw_cnt, e.sw);
          lw_cnt = 0;
          sw_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic emis, input logic erng,
                       input int elat, input int elw, input int esw);
    exp_t e;
    @(negedge clk);
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    e.rdata = erd;
    e.mis   = emis;
    e.rng   = erng;
    e.lat   = elat;
    e.lw    = elw;
    e.sw    = esw;
    e.idx   = {2'b00, addr[31:2]};
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]   = 32'h0BAD_F00D;
    ram[18]  = 32'h0000_F000;
    ram[20]  = 32'h1555_5555;
    ram[22]  = 32'h0006_8068;
    ram[30]  = 32'h1111_1111;
    ram[255] = 32'h8000_0000;

    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_enables", {30'd0, mem_lw_en, mem_sw_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     we    size   uns   addr          wdata         rdata         mis   rng   lat lw sw
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0,        32'h1555_5555, 1'b0, 1'b0, 2, 1, 0); // LW
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0049, 32'h0,        32'hFFFF_FFF0, 1'b0, 1'b0, 2, 1, 0); // LB
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0049, 32'h0,        32'h0000_00F0, 1'b0, 1'b0, 2, 1, 0); // LBU
    issue(1'b1, 2'b00, 1'b0, 32'h0000_005A, 32'h0000_00AB, 32'h0,        1'b0, 1'b0, 3, 1, 1); // SB
    chk("ram22_after_sb", ram[22], 32'h00AB_8068);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0053, 32'h0,        32'h0,         1'b1, 1'b0, 1, 0, 0); // LH misaligned
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5555_AAAA, 32'h0,        1'b0, 1'b1, 1, 0, 0); // SW out of range
    chk("ram0_after_range", ram[0], 32'h0BAD_F00D);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_004A, 32'h1234_8765, 32'h0,        1'b0, 1'b0, 3, 1, 1); // SH upper half
    chk("ram18_after_sh", ram[18], 32'h8765_F000);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_004A, 32'h0,        32'hFFFF_8765, 1'b0, 1'b0, 2, 1, 0); // LH
    issue(1'b0, 2'b01, 1'b1, 32'h0000_004A, 32'h0,        32'h0000_8765, 1'b0, 1'b0, 2, 1, 0); // LHU
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0054, 32'hCAFE_BABE, 32'h0,        1'b0, 1'b0, 2, 0, 1); // SW
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0054, 32'h0,        32'hCAFE_BABE, 1'b0, 1'b0, 2, 1, 0); // LW readback
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0050, 32'h0,        32'h0,         1'b1, 1'b0, 1, 0, 0); // size 11
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0401, 32'h0,        32'h0,         1'b1, 1'b1, 1, 0, 0); // both faults
    issue(1'b0, 2'b00, 1'b0, 32'h0000_03FF, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2, 1, 0); // LB last word

    // Reset landing in WR before the falling edge abandons the write.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0078;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("wr_sw_en_high", {31'd0, mem_sw_en}, 32'd1);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_sw_en_drop", {31'd0, mem_sw_en}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("ram30_unchanged", ram[30], 32'h1111_1111);
    @(negedge clk);
    rst_n  = 1'b1;
    lw_cnt = 0;
    sw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end
    chk("ram30_final", ram[30], 32'h1111_1111);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
